// File: rtl/dmem_pkg.sv
// Shared types for the dmem request interface between the L1 data caches and
// the data-memory responder.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 32;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    DmemIdle    = 2'd0,
    DmemBusy    = 2'd1,
    DmemRespond = 2'd2
  } dmem_state_e;

  typedef struct packed {
    logic [DMEM_ADDR_W-1:0]   addr;
    logic [DMEM_DATA_W-1:0]   wdata;
    logic [DMEM_DATA_W/8-1:0] wstrb;
    logic                     write;
  } dmem_req_t;

  function automatic int dmem_idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_sram_array.sv
// Word-wide backing store with per-byte write enables and a registered read
// port; kept separate so a technology SRAM macro can replace it.
module dmem_sram_array #(
  parameter int DEPTH      = 1024,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 10
) (
  input  logic                    clk,
  input  logic                    re,
  input  logic                    we,
  input  logic [IDX_WIDTH-1:0]    addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset, matching a real SRAM.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (wstrb[b]) begin
          mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Target end of the dmem request interface: accepts one request, waits
// LATENCY cycles, then answers for exactly one cycle.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 1024,
  parameter int                    LATENCY    = 2,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
  input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] mem_wstrb_i,
  input  logic                    mem_write_i,
  input  logic                    mem_read_i,
  output logic [DATA_WIDTH-1:0]   mem_rdata_o,
  output logic                    mem_ready_o,
  output logic                    mem_err_o,
  output logic                    proto_err_o
);

  localparam int                  IW       = dmem_idx_width(DEPTH);
  localparam int                  SW       = DATA_WIDTH/8;
  localparam logic [ADDR_WIDTH:0] LIMIT    = (ADDR_WIDTH+1)'(DEPTH) << 2;
  localparam logic [3:0]          CNT_LOAD = 4'(LATENCY - 1);

  dmem_state_e           state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [SW-1:0]         wstrb_q;
  logic                  write_q;

  logic                  req;
  logic [ADDR_WIDTH-1:0] offset;
  logic                  addr_err;
  logic [IW-1:0]         idx_q;
  logic [IW-1:0]         in_idx;
  logic [IW-1:0]         sram_addr;
  logic                  sram_re;
  logic                  sram_we;
  logic [DATA_WIDTH-1:0] sram_rdata;

  assign req      = mem_read_i | mem_write_i;
  assign offset   = addr_q - BASE_ADDR;
  assign addr_err = (addr_q < BASE_ADDR) | ({1'b0, offset} >= LIMIT) | (|addr_q[1:0]);
  assign idx_q    = IW'(offset >> 2);
  assign in_idx   = IW'((mem_addr_i - BASE_ADDR) >> 2);

  // Reads are launched at accept so the word is ready well before Respond;
  // writes commit on the Busy-to-Respond edge so a following read sees them.
  assign sram_addr = (state == DmemIdle) ? in_idx : idx_q;
  assign sram_re   = (state == DmemIdle) & mem_read_i & ~mem_write_i;
  assign sram_we   = (state == DmemBusy) & (cnt == 4'd0) & write_q & ~addr_err;

  assign mem_ready_o = (state != DmemBusy);

  dmem_sram_array #(
    .DEPTH     (DEPTH),
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_WIDTH (IW)
  ) u_sram (
    .clk  (clk),
    .re   (sram_re),
    .we   (sram_we),
    .addr (sram_addr),
    .wdata(wdata_q),
    .wstrb(wstrb_q),
    .rdata(sram_rdata)
  );

  // Transaction sequencer with registered response and sticky protocol flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= DmemIdle;
      cnt         <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      write_q     <= 1'b0;
      mem_rdata_o <= '0;
      mem_err_o   <= 1'b0;
      proto_err_o <= 1'b0;
    end else begin
      case (state)
        DmemIdle: begin
          mem_err_o <= 1'b0;
          if (req) begin
            addr_q  <= mem_addr_i;
            wdata_q <= mem_wdata_i;
            wstrb_q <= mem_wstrb_i;
            write_q <= mem_write_i;
            cnt     <= CNT_LOAD;
            state   <= DmemBusy;
            if (mem_read_i && mem_write_i) begin
              proto_err_o <= 1'b1;
            end
          end
        end
        DmemBusy: begin
          if (req) begin
            proto_err_o <= 1'b1;
          end
          if (cnt == 4'd0) begin
            state     <= DmemRespond;
            mem_err_o <= addr_err;
            if (!write_q) begin
              mem_rdata_o <= addr_err ? '0 : sram_rdata;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DmemRespond: begin
          mem_err_o <= 1'b0;
          state     <= DmemIdle;
          if (req) begin
            proto_err_o <= 1'b1;
          end
        end
        default: begin
          mem_err_o <= 1'b0;
          state     <= DmemIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Word-addressed data-memory responder; the target end of the dmem request interface driven by the L1 data caches.
- Accepts single-cycle read/write request pulses, waits a programmable number of cycles, then completes with a one-cycle response, with read data where applicable.
- Backs the cache verification environment and serves as the on-chip data SRAM controller.
- Byte-strobe writes, bounds/alignment checking, sticky protocol-violation flag.

Parameters:
- ADDR_WIDTH, 32, request address width in bits.
- DATA_WIDTH, 32, data word width in bits; must be a multiple of 8.
- DEPTH, 1024, number of words in the backing array (power of two).
- LATENCY, 2, cycles spent in Busy before Respond; legal range 1..15.
- BASE_ADDR, 0, byte address of word 0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- mem_addr_i  in  ADDR_WIDTH  byte address of request.
- mem_wdata_i  in  DATA_WIDTH  write data.
- mem_wstrb_i  in  DATA_WIDTH/8  byte enables for writes.
- mem_write_i  in  1  write request pulse.
- mem_read_i  in  1  read request pulse.
- mem_rdata_o  out  DATA_WIDTH  read data, valid while mem_ready_o is high in Respond.
- mem_ready_o  out  1  high in Idle (can accept) and in Respond (completion); low in Busy.
- mem_err_o  out  1  completion-cycle error: out of range or misaligned.
- proto_err_o  out  1  sticky: request seen while Busy, or read and write asserted together.

Behaviour:
- Interface: one clock, clk; asynchronous active-high reset, rst.
- Reset values: state Idle, counter 0, mem_rdata_o 0, mem_ready_o 1 (combinational from Idle), mem_err_o 0, proto_err_o 0. Array contents are not reset.
- Reset asserted mid-operation aborts the transaction. A pending write is discarded and the array is unchanged.

State machine (Idle, Busy, Respond):
- Idle: a request is mem_read_i or mem_write_i high. On a request, latch addr, wdata, wstrb and op; load counter with LATENCY-1; go to Busy.
- Simultaneous read and write in Idle: treated as a write; set proto_err_o.
- Busy: ready low. Counter decrements each cycle; at 0, go to Respond.
- Any request seen in Busy is ignored and sets proto_err_o.
- Respond: lasts exactly one cycle with mem_ready_o=1, then returns to Idle.
- A request in the Respond cycle is ignored and sets proto_err_o. Masters must wait for Idle.

Latency:
- Request at cycle T gives Respond at cycle T+LATENCY+1.
- Ready sequence is 1 (Idle), 0 x LATENCY (Busy), 1 (Respond), 1 (Idle).

Address decode:
- offset = addr - BASE_ADDR; word index = offset[log2(DEPTH)+1:2].
- Error if addr < BASE_ADDR, offset >= DEPTH*4, or addr[1:0] != 0.

Read:
- mem_rdata_o is registered with array[index] on entry to Respond and held until the next read completes.
- On error: mem_rdata_o = 0 and mem_err_o = 1 for the Respond cycle.

Write:
- Commit happens on the Busy-to-Respond edge. Only bytes with wstrb=1 are updated.
- wstrb=0 completes normally with no change.
- Error writes do not modify the array; mem_err_o pulses.
- Read-after-write to the same address returns the new data, because the commit precedes the next accept.

Other:
- mem_err_o is high only in Respond.
- proto_err_o clears only on reset.

Decomposition:
- Shared package dmem_pkg holds:
  - enum dmem_state_e {DmemIdle, DmemBusy, DmemRespond};
  - struct dmem_req_t {addr, wdata, wstrb, write};
  - localparam function for word-index width.
  The cache and this responder share the request struct.
- One sub-module: dmem_sram_array (DEPTH x DATA_WIDTH, per-byte write enable, synchronous read), so the array can be swapped for a technology macro.

Test Plan:
- Reset, then read 0x10 after preloading array[4]=0xDEADBEEF with LATENCY=2 -> ready pattern 1,0,0,1; rdata=0xDEADBEEF on the Respond cycle; mem_err_o=0.
- Write 0x10, wdata 0x11223344, wstrb 4'b0101, over 0xDEADBEEF; then read 0x10 -> rdata=0xDE22BE44.
- Read 0x13 (misaligned), then read BASE_ADDR+DEPTH*4 -> each Respond cycle has mem_err_o=1 and rdata=0; array unchanged.
- Issue a read, then pulse mem_write_i during Busy -> original read completes normally; proto_err_o=1 sticky; the second request is never performed.
- Read and write asserted together to 0x20, wdata 0xCAFEF00D, wstrb 4'hF -> treated as write; proto_err_o=1; a later read of 0x20 returns 0xCAFEF00D.
- Assert rst during Busy of a write to 0x30 -> outputs return to reset values asynchronously; a later read of 0x30 returns the pre-write value.
